// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into framed valid/ready bursts with sop/eop markers.
// Optional macro FIFO_BURST_READER_PAD_EN pads short timeout bursts with zero words up to BURST_LEN.
module fifo_burst_reader #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              src_sop_o,
  output logic              src_eop_o,
  output logic              busy_o
);

  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [AWIDTH:0] BL      = (AWIDTH + 1)'(BURST_LEN);
  localparam logic [AWIDTH:0] ONE     = (AWIDTH + 1)'(1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
  logic [AWIDTH:0]   rem_q, rem_d;
  logic [AWIDTH:0]   tot_q, tot_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic              real_word;
  logic              adv;

`ifdef FIFO_BURST_READER_PAD_EN
  logic [AWIDTH:0]   pad_q, pad_d;
  // The last pad_q slots of a burst carry zero words instead of FIFO data.
  assign real_word = (rem_q > pad_q);
`else
  assign real_word = 1'b1;
`endif

  assign adv = (state_q == BURST) && (rem_q != '0) && (!valid_q || src_ready_i) &&
               (!real_word || !fifo_empty_i);

  assign fifo_rdreq_o = adv && real_word && !srst_i;
  assign src_data_o   = data_q;
  assign src_valid_o  = valid_q;
  assign src_sop_o    = sop_q;
  assign src_eop_o    = eop_q;
  assign busy_o       = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    rem_d      = rem_q;
    tot_d      = tot_q;
    data_d     = data_q;
    valid_d    = valid_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
`ifdef FIFO_BURST_READER_PAD_EN
    pad_d      = pad_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_usedw_i >= BL) begin
          state_d    = BURST;
          idle_cnt_d = '0;
          rem_d      = BL;
          tot_d      = BL;
`ifdef FIFO_BURST_READER_PAD_EN
          pad_d      = '0;
`endif
        end else if (!fifo_empty_i && (idle_cnt_q == TO_LAST)) begin
          state_d    = BURST;
          idle_cnt_d = '0;
`ifdef FIFO_BURST_READER_PAD_EN
          rem_d      = BL;
          tot_d      = BL;
          pad_d      = BL - fifo_usedw_i;
`else
          rem_d      = fifo_usedw_i;
          tot_d      = fifo_usedw_i;
`endif
        end else if (fifo_empty_i) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      BURST: begin
        if (adv) begin
          data_d  = real_word ? fifo_q_i : '0;
          valid_d = 1'b1;
          sop_d   = (rem_q == tot_q);
          eop_d   = (rem_q == ONE);
          rem_d   = rem_q - ONE;
          if (rem_q == ONE) state_d = DRAIN;
        end else if (valid_q && src_ready_i) begin
          // Accepted word with nothing to replace it (FIFO ran dry mid-burst).
          valid_d = 1'b0;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
        end
      end
      DRAIN: begin
        if (valid_q && src_ready_i) begin
          valid_d = 1'b0;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
      rem_q      <= '0;
      tot_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
`ifdef FIFO_BURST_READER_PAD_EN
      pad_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      rem_q      <= rem_d;
      tot_q      <= tot_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
`ifdef FIFO_BURST_READER_PAD_EN
      pad_q      <= pad_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model, burst-framing scoreboard, randomized traffic.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BL = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst       = 1'b1;
  logic [DW-1:0] fifo_q     = '0;
  logic          fifo_empty = 1'b1;
  logic [AW:0]   fifo_usedw = '0;
  logic          src_ready  = 1'b1;
  logic          rdreq, src_valid, src_sop, src_eop, busy;
  logic [DW-1:0] src_data;

  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] fq[$];
  int            cyc      = 0;
  int            first_wr = 0;
  int            pops     = 0;

  // Second instance: single-word bursts.
  logic [DW-1:0] q1     = 32'h55;
  logic          ready1 = 1'b1;
  logic          u1_wr  = 1'b0;
  int            n1     = 0;
  int            beats1 = 0;
  logic          empty1;
  logic [AW:0]   usedw1;
  logic          rdreq1, valid1, sop1, eop1, busy1;
  logic [DW-1:0] data1;
  assign empty1 = (n1 == 0);
  assign usedw1 = (AW + 1)'(n1);

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
    .fifo_usedw_i(fifo_usedw), .fifo_rdreq_o(rdreq), .src_data_o(src_data),
    .src_valid_o(src_valid), .src_ready_i(src_ready), .src_sop_o(src_sop),
    .src_eop_o(src_eop), .busy_o(busy)
  );

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(1), .TIMEOUT(4)) dut1 (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(q1), .fifo_empty_i(empty1),
    .fifo_usedw_i(usedw1), .fifo_rdreq_o(rdreq1), .src_data_o(data1),
    .src_valid_o(valid1), .src_ready_i(ready1), .src_sop_o(sop1),
    .src_eop_o(eop1), .busy_o(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;
  beat_t exp_q[$];

  // Show-ahead FIFO model.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en && fq.size() == 0) first_wr <= cyc + 1;
    if (rdreq && fq.size() != 0) begin
      void'(fq.pop_front());
      pops <= pops + 1;
    end
    if (wr_en) fq.push_back(wr_data);
    fifo_q     <= (fq.size() != 0) ? fq[0] : '0;
    fifo_empty <= (fq.size() == 0);
    fifo_usedw <= (AW + 1)'(fq.size());
  end

  always @(posedge clk) begin
    n1 <= n1 + (u1_wr ? 1 : 0) - ((rdreq1 && n1 > 0) ? 1 : 0);
  end

  // Ready generator: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  int rdy_mode = 0;
  int rdy_k    = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1: begin
        src_ready = ((rdy_k % 4) == 0) || ((rdy_k % 4) == 3);
        rdy_k++;
      end
      2:       src_ready = ($urandom_range(0, 3) != 0);
      default: src_ready = 1'b1;
    endcase
  end

  // Output monitor and scoreboard.
  logic          prev_rd    = 1'b0;
  logic [DW-1:0] prev_head  = '0;
  logic          prev_stall = 1'b0;
  logic [DW+2:0] prev_out   = '0;
  logic          busy_chk   = 1'b0;
  int            hs_cnt     = 0;
  int            hs_cyc[$];

  always @(negedge clk) begin
    if (srst) begin
      prev_rd    <= 1'b0;
      prev_stall <= 1'b0;
      busy_chk   <= 1'b0;
    end else begin
      check_eq("rd_while_empty", rdreq & fifo_empty, 0);
      check_eq("rd_while_stalled", rdreq & src_valid & ~src_ready, 0);
      if (prev_rd) begin
        check_eq("pop_to_valid", src_valid, 1);
        check_eq("pop_data", src_data, prev_head);
      end
      if (prev_stall) check_eq("stall_hold", {src_valid, src_sop, src_eop, src_data}, prev_out);
      if (busy_chk) check_eq("busy_after_eop", busy, 0);
      if (src_valid && src_ready) begin
        hs_cnt <= hs_cnt + 1;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) check_eq("extra_beat", src_data, 64'hDEAD_0000_0000);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          check_eq("beat_data", src_data, b.d);
          check_eq("beat_sop", src_sop, b.sop);
          check_eq("beat_eop", src_eop, b.eop);
        end
      end
      busy_chk   <= src_valid & src_ready & src_eop;
      prev_rd    <= rdreq;
      prev_head  <= fifo_q;
      prev_stall <= src_valid & ~src_ready;
      prev_out   <= {src_valid, src_sop, src_eop, src_data};
    end
  end

  always @(negedge clk) begin
    if (!srst) begin
      check_eq("u1_rd_while_empty", rdreq1 & empty1, 0);
      if (valid1) begin
        beats1 <= beats1 + 1;
        check_eq("u1_data", data1, 32'h55);
        check_eq("u1_sop", sop1, 1);
        check_eq("u1_eop", eop1, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference framing: full bursts of BL while enough words remain, then one timeout burst.
  task automatic push_burst(input logic [DW-1:0] w[$], input int start, input int len);
    int total;
    total = len;
`ifdef FIFO_BURST_READER_PAD_EN
    total = BL;
`endif
    for (int k = 0; k < total; k++) begin
      beat_t b;
      b.d   = (k < len) ? w[start + k] : '0;
      b.sop = (k == 0);
      b.eop = (k == total - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic expect_stream(input logic [DW-1:0] w[$]);
    int i;
    i = 0;
    while (w.size() - i >= BL) begin
      push_burst(w, i, BL);
      i += BL;
    end
    if (i < w.size()) push_burst(w, i, w.size() - i);
  endtask

  task automatic write_words(input logic [DW-1:0] w[$]);
    foreach (w[k]) begin
      wr_en   = 1'b1;
      wr_data = w[k];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && fq.size() == 0 && !busy) && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, (k < budget), 1);
    exp_q.delete();
    tick();
    tick();
  endtask

  initial begin
    logic [DW-1:0] w[$];
    int p0, k, lvl;

    srst = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", src_valid, 0);
    check_eq("rst_rdreq", rdreq, 0);
    check_eq("rst_sop", src_sop, 0);
    check_eq("rst_eop", src_eop, 0);
    check_eq("rst_data", src_data, 0);
    check_eq("rst_busy", busy, 0);
    srst = 1'b0;
    tick();

    // Full burst with ready always high.
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back(DW'(32'h10 + i));
    expect_stream(w);
    hs_cyc.delete();
    p0 = pops;
    rdy_mode = 0;
    write_words(w);
    wait_done("full_done", 200);
    check_eq("full_beats", hs_cyc.size(), 8);
    if (hs_cyc.size() == 8) check_eq("full_back_to_back", hs_cyc[7] - hs_cyc[0], 7);
    check_eq("full_pops", pops - p0, 8);

    // Backpressure pattern 1,0,0,1.
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back($urandom);
    expect_stream(w);
    rdy_k = 0;
    rdy_mode = 1;
    write_words(w);
    wait_done("bp_done", 300);
    rdy_mode = 0;

    // Timeout burst of three words.
    w.delete();
    w.push_back(32'hA); w.push_back(32'hB); w.push_back(32'hC);
    expect_stream(w);
    write_words(w);
    k = 0;
    while (!rdreq && k < 100) begin
      tick();
      k++;
    end
    check_eq("timeout_start", cyc - first_wr, TO);
    wait_done("timeout_done", 200);

    // Words arriving during a burst go into the next one.
    w.delete();
    for (int i = 0; i < 12; i++) w.push_back($urandom);
    expect_stream(w);
    write_words(w);
    wait_done("growth_done", 300);

    // Reset after three accepted words.
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back($urandom);
    expect_stream(w);
    hs_cnt = 0;
    write_words(w);
    k = 0;
    while (hs_cnt < 3 && k < 100) begin
      tick();
      k++;
    end
    check_eq("rst_mid_reached", (k < 100), 1);
    srst = 1'b1;
    lvl = fq.size();
    tick();
    check_eq("rst_mid_valid", src_valid, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_fifo_kept", fq.size(), lvl);
    srst = 1'b0;
    exp_q.delete();
    w = fq;
    expect_stream(w);
    wait_done("rst_mid_done", 300);

    // Randomized fills and ready patterns.
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 16);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      expect_stream(w);
      rdy_k = 0;
      rdy_mode = $urandom_range(0, 2);
      write_words(w);
      wait_done("rand_done", 400);
    end
    rdy_mode = 0;

    // Single-word bursts on the BURST_LEN=1 instance.
    u1_wr = 1'b1;
    tick();
    u1_wr = 1'b0;
    repeat (10) tick();
    check_eq("u1_beats", beats1, 1);
    check_eq("u1_fifo_drained", n1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
